dec2e_scan_ctrl: RTL and testbench
==================================

Name: dec2e_scan_ctrl

Overview:
- Sequential driver sitting directly upstream of the 2-output enabled decoder (Dec2E).
- Generates the decoder's enable (E) and address (A0) to time-multiplex two loads (e.g. two display digits).
- Each output is selected for a programmable dwell time.
- A programmable blanking gap with E=0 separates selections, to prevent ghosting.
- Also provides a frame pulse and a frame counter for downstream bookkeeping.

Parameters:
- DWELL, 100: clock cycles E is held 1 per selection; legal range 1..65535.
- BLANK, 4: clock cycles E is held 0 before each selection; legal range 0..255. 0 means no blanking.
- FCNT_W, 8: width of frame_cnt.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  run request; sampled every rising edge.
- A0  output  1  decoder address; registered.
- E  output  1  decoder enable; registered.
- frame_tick  output  1  one-cycle pulse when a full frame (address 0 then address 1) completes; registered.
- frame_cnt  output  FCNT_W  completed-frame count; registered; wraps.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk, and has priority over everything.
- Reset values: state=IDLE, A0=0, E=0, frame_tick=0, frame_cnt=0, internal counter=0.
- All outputs are registered decodes of state and counter. There is no combinational path from en to any output.
- FSM states: IDLE, BLANK, DRIVE.
- IDLE:
  - Outputs: E=0, A0=0.
  - en=1 at edge n: go to BLANK with counter=0. If BLANK=0, go straight to DRIVE, so E=1 after edge n.
- BLANK:
  - E=0; A0 already holds the address about to be driven.
  - Counter increments each cycle.
  - Exactly BLANK cycles of E=0, then go to DRIVE with counter=0.
- DRIVE:
  - E=1 for exactly DWELL cycles.
  - On the edge ending the dwell: A0 toggles, counter clears, go to BLANK (or stay in DRIVE with E=1 at the new address if BLANK=0).
- Timing from IDLE (en sampled 1 at edge n):
  - E rises after edge n+BLANK.
  - E falls after edge n+BLANK+DWELL.
  - Frame period is 2*(BLANK+DWELL) cycles.
- Address change and E:
  - A0 only changes on the same edge where E falls, or in the BLANK=0 case on a dwell boundary.
  - A0 never changes while E=1 within a dwell.
- Frame completion: on the edge where A0 goes 1→0 at the end of a dwell:
  - frame_tick=1 for exactly one cycle.
  - frame_cnt increments modulo 2^FCNT_W (e.g. 255→0 for FCNT_W=8, with no other side effect).
- en deasserted:
  - en=0 sampled in BLANK or DRIVE: go to IDLE on that edge; E=0, A0=0, counter cleared.
  - No frame_tick is generated; frame_cnt is unchanged. The partial frame is discarded.
- en re-asserted: restarts from address 0 with a full BLANK gap.
- rst mid-operation: all outputs return to reset values after that edge, regardless of en.
- Counter is 16 bits, shared by BLANK and DRIVE; it must never exceed max(DWELL,BLANK)-1.
- Invariant: at most one decoder output is active at any time, guaranteed because E and A0 come from one registered FSM.

Test Plan:
- DWELL=3, BLANK=2. rst 2 cycles, then en=1 at edge 3 -> E=0 after edges 3,4. E=1, A0=0 after edges 5..7. E=0, A0=1 after edges 8,9. E=1, A0=1 after edges 10..12. A0=0, frame_tick=1 for one cycle after edge 13; frame_cnt=1.
- BLANK=0, DWELL=2, en held high -> E constantly 1, A0 toggles every 2 cycles, frame_tick every 4 cycles.
- en dropped mid-DRIVE at address 1 -> next cycle E=0, A0=0, frame_tick=0, frame_cnt unchanged. Re-asserting en restarts with a BLANK gap at address 0.
- rst asserted mid-BLANK with en=1 -> all outputs 0 after that edge. Restart timing after rst release matches the first scenario.
- FCNT_W=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1; one frame_tick per frame.
- Connect to Dec2E and run long: checker asserts Y never has both bits 1, and asserts A0 is stable whenever E=1 across consecutive cycles within a dwell.

Source files
------------

// File: rtl/dec2e_scan_ctrl_if.sv
// Signal bundle between the scan controller and its Dec2E decoder / bookkeeping consumer.
// The master side is the controller: it takes the run request and drives the decoder controls.
interface dec2e_scan_ctrl_if #(
  parameter int unsigned FCNT_W = 8
);
  logic              en;
  logic              A0;
  logic              E;
  logic              frame_tick;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (input en, output A0, E, frame_tick, frame_cnt);
  modport slave  (output en, input A0, E, frame_tick, frame_cnt);
endinterface

// File: rtl/dec2e_scan_ctrl.sv
// Time-multiplexing driver for a 2-output enabled decoder: alternates A0 with a dwell of E=1
// separated by blanking gaps of E=0, and counts completed frames (address 0 then address 1).
module dec2e_scan_ctrl #(
  parameter int unsigned DWELL  = 100,
  parameter int unsigned BLANK  = 4,
  parameter int unsigned FCNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  dec2e_scan_ctrl_if.master scan
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0] BLANK_LAST = (BLANK > 0) ? 16'(BLANK - 1) : '0;
  localparam state_t      START_ST   = (BLANK == 0) ? S_DRIVE : S_BLANK;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              a0_q, a0_d;
  logic              e_q, e_d;
  logic              tick_q, tick_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a0_q    <= 1'b0;
      e_q     <= 1'b0;
      tick_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a0_q    <= a0_d;
      e_q     <= e_d;
      tick_q  <= tick_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a0_d    = a0_q;
    tick_d  = 1'b0;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        a0_d  = 1'b0;
        if (scan.en) state_d = START_ST;
      end
      S_BLANK: begin
        if (!scan.en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          a0_d    = 1'b0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DRIVE: begin
        if (!scan.en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          a0_d    = 1'b0;
        end else if (cnt_q == DWELL_LAST) begin
          // End of dwell: swap address; leaving address 1 closes a frame.
          state_d = START_ST;
          cnt_d   = '0;
          a0_d    = ~a0_q;
          if (a0_q) begin
            tick_d = 1'b1;
            fcnt_d = fcnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        a0_d    = 1'b0;
      end
    endcase
    // E is a registered decode of the next state, so it tracks state_q one-for-one.
    e_d = (state_d == S_DRIVE);
  end

  assign scan.A0         = a0_q;
  assign scan.E          = e_q;
  assign scan.frame_tick = tick_q;
  assign scan.frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_dec2e_scan_ctrl.sv
// Scoreboard bench for dec2e_scan_ctrl: three configurations run side by side against a
// position-in-frame reference model; expected outputs are queued at each edge and checked 1 time unit later.
module tb_dec2e_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dec2e_scan_ctrl_if #(.FCNT_W(8)) bus_a ();
  dec2e_scan_ctrl_if #(.FCNT_W(8)) bus_b ();
  dec2e_scan_ctrl_if #(.FCNT_W(2)) bus_c ();

  assign bus_a.en = en_a;
  assign bus_b.en = en_b;
  assign bus_c.en = en_c;

  dec2e_scan_ctrl #(.DWELL(3), .BLANK(2), .FCNT_W(8)) u_a (.clk(clk), .rst(rst), .scan(bus_a));
  dec2e_scan_ctrl #(.DWELL(2), .BLANK(0), .FCNT_W(8)) u_b (.clk(clk), .rst(rst), .scan(bus_b));
  dec2e_scan_ctrl #(.DWELL(3), .BLANK(2), .FCNT_W(2)) u_c (.clk(clk), .rst(rst), .scan(bus_c));

  // Dec2E outputs built from each controller's E/A0.
  logic [1:0] y_a, y_b, y_c;
  assign y_a = {bus_a.E & bus_a.A0, bus_a.E & ~bus_a.A0};
  assign y_b = {bus_b.E & bus_b.A0, bus_b.E & ~bus_b.A0};
  assign y_c = {bus_c.E & bus_c.A0, bus_c.E & ~bus_c.A0};

  always @(negedge clk) begin
    assert (y_a != 2'b11 && y_b != 2'b11 && y_c != 2'b11)
      else $error("decoder drove both outputs");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pack(input logic [7:0] fc, input logic tick, input logic e, input logic a0);
    return (int'(fc) << 3) | (int'(tick) << 2) | (int'(e) << 1) | int'(a0);
  endfunction

  // k counts edges since the edge that sampled en=1 from idle; outputs follow from k mod frame period.
  task automatic model_step(input int b, input int d, input int w, input logic r, input logic e,
                            inout int run, inout int k, inout int fc, output int ev);
    int p, half, q;
    logic tick, ee, a;
    tick = 1'b0; ee = 1'b0; a = 1'b0;
    if (r) begin
      run = 0; k = 0; fc = 0;
    end else if (!e) begin
      run = 0; k = 0;
    end else begin
      if (run == 0) begin
        run = 1; k = 0;
      end else begin
        k++;
      end
      p    = k % (2 * (b + d));
      half = p / (b + d);
      q    = p % (b + d);
      a    = (half == 1);
      ee   = (q >= b);
      if (k > 0 && p == 0) begin
        tick = 1'b1;
        fc   = (fc + 1) % (1 << w);
      end
    end
    ev = (fc << 3) | (int'(tick) << 2) | (int'(ee) << 1) | int'(a);
  endtask

  int q_a[$], q_b[$], q_c[$];

  initial begin
    int run_a = 0, k_a = 0, fc_a = 0;
    int run_b = 0, k_b = 0, fc_b = 0;
    int run_c = 0, k_c = 0, fc_c = 0;
    int ev;
    logic pe_a = 1'b0, pa_a = 1'b0, pe_c = 1'b0, pa_c = 1'b0;
    forever begin
      @(posedge clk);
      model_step(2, 3, 8, rst, en_a, run_a, k_a, fc_a, ev); q_a.push_back(ev);
      model_step(0, 2, 8, rst, en_b, run_b, k_b, fc_b, ev); q_b.push_back(ev);
      model_step(2, 3, 2, rst, en_c, run_c, k_c, fc_c, ev); q_c.push_back(ev);
      #1;
      chk("cfgA", pack(bus_a.frame_cnt, bus_a.frame_tick, bus_a.E, bus_a.A0), q_a.pop_front());
      chk("cfgB", pack(8'(bus_b.frame_cnt), bus_b.frame_tick, bus_b.E, bus_b.A0), q_b.pop_front());
      chk("cfgC", pack(8'(bus_c.frame_cnt), bus_c.frame_tick, bus_c.E, bus_c.A0), q_c.pop_front());
      if (pe_a && bus_a.E) chk("a0_hold_A", int'(bus_a.A0), int'(pa_a));
      if (pe_c && bus_c.E) chk("a0_hold_C", int'(bus_c.A0), int'(pa_c));
      pe_a = bus_a.E; pa_a = bus_a.A0;
      pe_c = bus_c.E; pa_c = bus_c.A0;
    end
  end

  initial begin
    bit found;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    en_a = 1'b1;
    en_b = 1'b1;
    en_c = 1'b1;
    repeat (25) @(negedge clk);

    // Drop en in the middle of the address-1 dwell.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus_a.E && bus_a.A0) found = 1'b1;
      else @(negedge clk);
    end
    chk("wait_drive_a1", int'(found), 1);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);

    // Reset during the restart blanking gap, with en still high.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
